// File: rtl/pic_mem_subsystem.sv
// Program ROM (2048x14, fixed image) and data RAM (128x8) for the PIC-style multicycle CPU.
// Both memories read combinationally; RAM writes and the synchronous clear act on rising clk.
module pic_mem_subsystem (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] Rom_addr_in,
    output logic [13:0] Rom_data_out,
    input  logic [6:0]  addr,
    input  logic [7:0]  data,
    input  logic        ram_en,
    output logic [7:0]  q
);

    localparam int unsigned RamDepth = 128;

    logic [7:0] mem_q [RamDepth];
    logic [7:0] mem_d [RamDepth];

    // Program image; every unlisted word decodes as NOP.
    always_comb begin
        unique case (Rom_addr_in)
            11'd0:   Rom_data_out = 14'h3005;
            11'd1:   Rom_data_out = 14'h00A0;
            11'd2:   Rom_data_out = 14'h3E03;
            11'd3:   Rom_data_out = 14'h07A0;
            11'd4:   Rom_data_out = 14'h0A20;
            11'd5:   Rom_data_out = 14'h2800;
            default: Rom_data_out = 14'h0000;
        endcase
    end

    // Clear takes priority over a pending write in the same cycle.
    always_comb begin
        mem_d = mem_q;
        if (rst) begin
            for (int i = 0; i < RamDepth; i++) begin
                mem_d[i] = 8'h00;
            end
        end else if (ram_en) begin
            mem_d[addr] = data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // No write-through: q shows the stored word until the writing edge.
    assign q = mem_q[addr];

endmodule

// File: tb/tb_pic_mem_subsystem.sv
// Self-checking bench for pic_mem_subsystem: expected values are queued when stimulus is
// driven and popped when the DUT output is sampled; a shadow RAM model tracks contents.
module tb_pic_mem_subsystem;

    logic        clk;
    logic        rst;
    logic [10:0] Rom_addr_in;
    logic [13:0] Rom_data_out;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic        ram_en;
    logic [7:0]  q;

    int unsigned passed;
    int unsigned total;
    logic [13:0] exp_q [$];
    logic [13:0] exp;
    logic [7:0]  model [128];

    pic_mem_subsystem dut (
        .clk          (clk),
        .rst          (rst),
        .Rom_addr_in  (Rom_addr_in),
        .Rom_data_out (Rom_data_out),
        .addr         (addr),
        .data         (data),
        .ram_en       (ram_en),
        .q            (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one clock edge with the given controls and mirrors its effect in the model.
    task automatic edge_cycle(input logic r, input logic en, input logic [6:0] a,
                              input logic [7:0] d);
        @(negedge clk);
        rst = r;
        ram_en = en;
        addr = a;
        data = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 128; i++) model[i] = 8'h00;
        end else if (en) begin
            model[a] = d;
        end
        #1;
        rst = 1'b0;
        ram_en = 1'b0;
    endtask

    task automatic test_reset();
        edge_cycle(1'b1, 1'b0, 7'h00, 8'h00);
        foreach (model[i]) model[i] = 8'h00;
        for (int i = 0; i < 128; i += 37) begin
            addr = 7'(i);
            exp_q.push_back(14'h0000);
            #1;
            exp = exp_q.pop_front();
            total++;
            if (q !== exp[7:0]) $display("FAIL reset_q addr=%0h got=%h want=%h", i, q, exp[7:0]);
            else passed++;
        end
    endtask

    task automatic test_rom_sweep();
        logic [10:0] a_tab [8];
        logic [13:0] d_tab [8];
        a_tab = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd2047};
        d_tab = '{14'h3005, 14'h00A0, 14'h3E03, 14'h07A0, 14'h0A20, 14'h2800, 14'h0000,
                  14'h0000};
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            Rom_addr_in = a_tab[i];
            exp_q.push_back(d_tab[i]);
            #1;
            exp = exp_q.pop_front();
            total++;
            if (Rom_data_out !== exp)
                $display("FAIL rom addr=%0d got=%h want=%h", a_tab[i], Rom_data_out, exp);
            else passed++;
        end
    endtask

    task automatic test_ram_reset();
        edge_cycle(1'b0, 1'b1, 7'h20, 8'hAA);
        edge_cycle(1'b0, 1'b1, 7'h7F, 8'h55);
        addr = 7'h7F;
        exp_q.push_back({6'd0, model[7'h7F]});
        #1;
        exp = exp_q.pop_front();
        total++;
        if (q !== exp[7:0]) $display("FAIL pre_reset_7f got=%h want=%h", q, exp[7:0]);
        else passed++;
        edge_cycle(1'b1, 1'b0, 7'h20, 8'h00);
        for (int i = 0; i < 2; i++) begin
            addr = (i == 0) ? 7'h20 : 7'h7F;
            exp_q.push_back({6'd0, model[addr]});
            #1;
            exp = exp_q.pop_front();
            total++;
            if (q !== exp[7:0]) $display("FAIL ram_reset addr=%h got=%h want=%h", addr, q, exp[7:0]);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        addr = 7'h20;
        data = 8'h05;
        ram_en = 1'b1;
        exp_q.push_back(14'h0000);
        #1;
        exp = exp_q.pop_front();
        total++;
        if (q !== exp[7:0]) $display("FAIL write_before_edge got=%h want=%h", q, exp[7:0]);
        else passed++;
        @(posedge clk);
        model[7'h20] = 8'h05;
        #1;
        ram_en = 1'b0;
        exp_q.push_back(14'h0005);
        exp = exp_q.pop_front();
        total++;
        if (q !== exp[7:0]) $display("FAIL write_after_edge got=%h want=%h", q, exp[7:0]);
        else passed++;
        addr = 7'h21;
        exp_q.push_back(14'h0000);
        #1;
        exp = exp_q.pop_front();
        total++;
        if (q !== exp[7:0]) $display("FAIL read_other_addr got=%h want=%h", q, exp[7:0]);
        else passed++;
    endtask

    task automatic test_rmw();
        @(negedge clk);
        addr = 7'h20;
        #1;
        edge_cycle(1'b0, 1'b1, 7'h20, q + 8'h08);
        exp_q.push_back(14'h000D);
        exp = exp_q.pop_front();
        total++;
        if (q !== exp[7:0]) $display("FAIL rmw got=%h want=%h", q, exp[7:0]);
        else passed++;
    endtask

    task automatic test_priority_hold();
        edge_cycle(1'b0, 1'b1, 7'h10, 8'hAB);
        edge_cycle(1'b1, 1'b1, 7'h10, 8'hFF);
        exp_q.push_back(14'h0000);
        exp = exp_q.pop_front();
        total++;
        if (q !== exp[7:0]) $display("FAIL rst_over_en got=%h want=%h", q, exp[7:0]);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            edge_cycle(1'b0, 1'b0, 7'h10, 8'h33);
            exp_q.push_back({6'd0, model[7'h10]});
            exp = exp_q.pop_front();
            total++;
            if (q !== exp[7:0]) $display("FAIL hold cycle=%0d got=%h want=%h", i, q, exp[7:0]);
            else passed++;
        end
    endtask

    task automatic test_boundary();
        edge_cycle(1'b0, 1'b1, 7'h00, 8'h11);
        edge_cycle(1'b0, 1'b1, 7'h7F, 8'h22);
        for (int i = 0; i < 128; i++) begin
            addr = 7'(i);
            exp_q.push_back({6'd0, model[i]});
            #1;
            exp = exp_q.pop_front();
            total++;
            if (q !== exp[7:0]) $display("FAIL boundary addr=%h got=%h want=%h", i, q, exp[7:0]);
            else passed++;
        end
        total++;
        if (model[0] !== 8'h11 || model[127] !== 8'h22 || exp_q.size() != 0)
            $display("FAIL boundary_model got=%h/%h want=11/22", model[0], model[127]);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        rst = 1'b0;
        ram_en = 1'b0;
        addr = 7'h00;
        data = 8'h00;
        Rom_addr_in = 11'd0;
        test_reset();
        test_rom_sweep();
        test_ram_reset();
        test_write_read();
        test_rmw();
        test_priority_hold();
        test_boundary();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
